// File: rtl/permute_fsm_if.sv
// Handshake and control bundle between the SHAKE load stage, the permute FSM
// and the dump stage. The slave modport is the FSM; master is its environment.
interface permute_fsm_if #(
  parameter int OUT_BLK_W = 16
);
  logic                 input_buffer_ready_wr;
  logic                 last_block_in_buffer_wr;
  logic [OUT_BLK_W-1:0] output_blocks;
  logic                 output_buffer_clear;
  logic                 input_buffer_ready;
  logic                 output_buffer_ready;
  logic                 last_output_block;
  logic                 state_reset;
  logic                 absorb_enable;
  logic                 round_enable;
  logic [4:0]           round_index;
  logic                 squeeze_copy;

  modport master (
    output input_buffer_ready_wr, last_block_in_buffer_wr, output_blocks, output_buffer_clear,
    input  input_buffer_ready, output_buffer_ready, last_output_block, state_reset,
           absorb_enable, round_enable, round_index, squeeze_copy
  );

  modport slave (
    input  input_buffer_ready_wr, last_block_in_buffer_wr, output_blocks, output_buffer_clear,
    output input_buffer_ready, output_buffer_ready, last_output_block, state_reset,
           absorb_enable, round_enable, round_index, squeeze_copy
  );
endinterface

// File: rtl/permute_fsm.sv
// Control FSM for the SHAKE permute stage: absorb, round sequencing and squeeze.
// Optional build macro PERMUTE_ROUND_UNROLL2_EN: two rounds per round_enable.
module permute_fsm #(
  parameter int ROUNDS    = 24,
  parameter int OUT_BLK_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  permute_fsm_if.slave bus
);

`ifdef PERMUTE_ROUND_UNROLL2_EN
  localparam logic [4:0] ROUND_STEP = 5'd2;
`else
  localparam logic [4:0] ROUND_STEP = 5'd1;
`endif
  localparam logic [4:0]           LAST_ROUND = 5'(ROUNDS) - ROUND_STEP;
  localparam logic [OUT_BLK_W-1:0] ZERO_BLK   = {OUT_BLK_W{1'b0}};
  localparam logic [OUT_BLK_W-1:0] ONE_BLK    = {{(OUT_BLK_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_RESET        = 3'd0,
    ST_IDLE         = 3'd1,
    ST_ABSORB       = 3'd2,
    ST_PERMUTE      = 3'd3,
    ST_SQUEEZE_WAIT = 3'd4
  } state_e;

  state_e               state_r;
  state_e               next_state_s;
  logic                 run_r;
  logic                 in_flag_r;
  logic                 last_blk_r;
  logic                 msg_last_r;
  logic                 out_flag_r;
  logic                 last_out_r;
  logic [4:0]           round_cnt_r;
  logic [4:0]           cnt_next_s;
  logic [OUT_BLK_W-1:0] remaining_r;
  logic                 absorb_s;
  logic                 round_en_s;
  logic                 copy_s;
  logic                 state_reset_s;
  logic                 final_s;

  // A zero remaining count can only come from a corrupted register; treat it as final.
  assign final_s = (remaining_r <= ONE_BLK);

  // State register; run_r keeps state_reset low while rst is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_RESET;
      run_r       <= 1'b0;
      round_cnt_r <= 5'd0;
    end else begin
      state_r     <= next_state_s;
      run_r       <= 1'b1;
      round_cnt_r <= cnt_next_s;
    end
  end

  // Next-state, round counter and datapath enables.
  always_comb begin
    next_state_s  = state_r;
    cnt_next_s    = round_cnt_r;
    absorb_s      = 1'b0;
    round_en_s    = 1'b0;
    copy_s        = 1'b0;
    state_reset_s = 1'b0;
    case (state_r)
      ST_RESET: begin
        state_reset_s = run_r;
        if (run_r) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESET;
        end
      end
      ST_IDLE: begin
        if (in_flag_r) begin
          next_state_s = ST_ABSORB;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ABSORB: begin
        absorb_s     = 1'b1;
        cnt_next_s   = 5'd0;
        next_state_s = ST_PERMUTE;
      end
      ST_PERMUTE: begin
        round_en_s = 1'b1;
        if (round_cnt_r >= LAST_ROUND) begin
          cnt_next_s = 5'd0;
          if (msg_last_r) begin
            next_state_s = ST_SQUEEZE_WAIT;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else begin
          cnt_next_s   = round_cnt_r + ROUND_STEP;
          next_state_s = ST_PERMUTE;
        end
      end
      ST_SQUEEZE_WAIT: begin
        if (!out_flag_r) begin
          copy_s     = 1'b1;
          cnt_next_s = 5'd0;
          // The copy samples the state before this same-cycle reset takes effect.
          if (final_s) begin
            state_reset_s = 1'b1;
            next_state_s  = ST_IDLE;
          end else begin
            next_state_s = ST_PERMUTE;
          end
        end else begin
          next_state_s = ST_SQUEEZE_WAIT;
        end
      end
      default: begin
        next_state_s = ST_RESET;
        cnt_next_s   = 5'd0;
      end
    endcase
  end

  // Handshake flags, message bookkeeping and output-block countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flag_r   <= 1'b0;
      last_blk_r  <= 1'b0;
      msg_last_r  <= 1'b0;
      out_flag_r  <= 1'b0;
      last_out_r  <= 1'b0;
      remaining_r <= ZERO_BLK;
    end else begin
      if (bus.input_buffer_ready_wr) begin
        in_flag_r  <= 1'b1;
        last_blk_r <= bus.last_block_in_buffer_wr;
      end else if (absorb_s) begin
        in_flag_r <= 1'b0;
      end

      if (absorb_s) begin
        msg_last_r <= last_blk_r;
        if (last_blk_r) begin
          remaining_r <= (bus.output_blocks == ZERO_BLK) ? ONE_BLK : bus.output_blocks;
        end
      end

      if (copy_s) begin
        out_flag_r <= 1'b1;
        last_out_r <= (remaining_r == ONE_BLK);
        if (remaining_r != ZERO_BLK) begin
          remaining_r <= remaining_r - ONE_BLK;
        end
      end else if (bus.output_buffer_clear) begin
        out_flag_r <= 1'b0;
      end
    end
  end

  assign bus.input_buffer_ready  = in_flag_r;
  assign bus.output_buffer_ready = out_flag_r;
  assign bus.last_output_block   = last_out_r;
  assign bus.state_reset         = state_reset_s;
  assign bus.absorb_enable       = absorb_s;
  assign bus.round_enable        = round_en_s;
  assign bus.round_index         = round_cnt_r;
  assign bus.squeeze_copy        = copy_s;

endmodule

// File: tb/tb_permute_fsm.sv
// Scoreboard bench for permute_fsm: stimulus queues expected control events,
// a monitor pops and compares them as the DUT raises its enables.
module tb_permute_fsm;
  localparam int ROUNDS = 24;
`ifdef PERMUTE_ROUND_UNROLL2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int NR = ROUNDS / STEP;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   clr_delay = 10;
  int   last_abs_cyc = 0;
  int   last_copy_cyc = 0;
  bit   pend_last = 1'b0;
  bit   exp_last = 1'b0;

  // event word: {state_reset, absorb_enable, round_enable, squeeze_copy, round_index}
  logic [8:0] ev_q[$];
  bit         last_q[$];
  int         copy_gap_q[$];
  int         abs_gap_q[$];

  permute_fsm_if #(.OUT_BLK_W(16)) bus ();

  permute_fsm #(.ROUNDS(ROUNDS), .OUT_BLK_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] ev(input bit sr, input bit ab, input bit re, input bit sq, input int idx);
    return {sr, ab, re, sq, 5'(idx)};
  endfunction

  function automatic void push_rounds(input int upto);
    for (int r = 0; r <= upto; r += STEP) ev_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, r));
  endfunction

  function automatic void push_block(input bit last, input int nout, input int abs_gap);
    int n;
    int g;
    ev_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 0));
    abs_gap_q.push_back(abs_gap);
    push_rounds(ROUNDS - STEP);
    if (last) begin
      n = (nout == 0) ? 1 : nout;
      g = (clr_delay + 2 > NR + 1) ? clr_delay + 2 : NR + 1;
      for (int k = 1; k <= n; k++) begin
        ev_q.push_back(ev(k == n, 1'b0, 1'b0, 1'b1, 0));
        last_q.push_back(k == n);
        copy_gap_q.push_back((k == 1) ? 0 : g);
        if (k < n) push_rounds(ROUNDS - STEP);
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send_block(input bit last, input int nout);
    @(negedge clk);
    bus.input_buffer_ready_wr   = 1'b1;
    bus.last_block_in_buffer_wr = last;
    bus.output_blocks           = 16'(nout);
    @(negedge clk);
    bus.input_buffer_ready_wr   = 1'b0;
    bus.last_block_in_buffer_wr = 1'b0;
    check("ibr_after_wr", int'(bus.input_buffer_ready), 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((ev_q.size() != 0 || pend_last) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ev_q.size() != 0 || pend_last) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", ev_q.size());
      ev_q.delete(); last_q.delete(); copy_gap_q.delete(); abs_gap_q.delete();
      pend_last = 1'b0;
    end
    repeat (clr_delay + 5) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ibr"}, int'(bus.input_buffer_ready), 0);
    check({tag, "_obr"}, int'(bus.output_buffer_ready), 0);
    check({tag, "_lob"}, int'(bus.last_output_block), 0);
    check({tag, "_sr"},  int'(bus.state_reset), 0);
    check({tag, "_ab"},  int'(bus.absorb_enable), 0);
    check({tag, "_re"},  int'(bus.round_enable), 0);
    check({tag, "_sq"},  int'(bus.squeeze_copy), 0);
    check({tag, "_idx"}, int'(bus.round_index), 0);
  endtask

  // Monitor: pop and compare one expected event per active DUT cycle.
  initial begin : monitor
    logic [8:0] act;
    logic [8:0] exp;
    int g;
    forever begin
      @(negedge clk);
      if (pend_last) begin
        pend_last = 1'b0;
        check("last_output_block", int'(bus.last_output_block), int'(exp_last));
        check("obr_after_copy", int'(bus.output_buffer_ready), 1);
      end
      act = {bus.state_reset, bus.absorb_enable, bus.round_enable, bus.squeeze_copy, bus.round_index};
      if (act[8:5] != 4'b0000) begin
        checks++;
        if (ev_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event actual=%b required=none", act);
        end else begin
          exp = ev_q.pop_front();
          if ((exp[6] && act != exp) || (!exp[6] && act[8:5] != exp[8:5])) begin
            failures++;
            $display("FAIL event actual=%b required=%b", act, exp);
          end
        end
        if (act[7] && abs_gap_q.size() != 0) begin
          g = abs_gap_q.pop_front();
          if (g != 0) check("absorb_gap", cyc - last_abs_cyc, g);
          last_abs_cyc = cyc;
        end
        if (act[5]) begin
          check("copy_while_full", int'(bus.output_buffer_ready), 0);
          if (copy_gap_q.size() != 0) begin
            g = copy_gap_q.pop_front();
            if (g != 0) check("copy_gap", cyc - last_copy_cyc, g);
          end
          last_copy_cyc = cyc;
          if (last_q.size() != 0) begin
            exp_last  = last_q.pop_front();
            pend_last = 1'b1;
          end
        end
      end
    end
  end

  // Dump-stage model: clear the output buffer clr_delay cycles after it fills.
  initial begin : dump_stage
    bus.output_buffer_clear = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.output_buffer_ready) begin
        repeat (clr_delay) @(negedge clk);
        bus.output_buffer_clear = 1'b1;
        @(negedge clk);
        bus.output_buffer_clear = 1'b0;
      end
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d required<60000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit found;
    bus.input_buffer_ready_wr   = 1'b0;
    bus.last_block_in_buffer_wr = 1'b0;
    bus.output_blocks           = 16'd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    ev_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 0));
    rst = 1'b1;
    wait_drain(20);

    // single block, one output block
    push_block(1'b1, 1, 0);
    send_block(1'b1, 1);
    wait_drain(500);

    // two-block message, second block published during PERMUTE
    push_block(1'b0, 0, 0);
    push_block(1'b1, 1, NR + 2);
    send_block(1'b0, 0);
    repeat (3) @(negedge clk);
    send_block(1'b1, 1);
    wait_drain(500);

    // three output blocks, quick dump stage
    clr_delay = 10;
    push_block(1'b1, 3, 0);
    send_block(1'b1, 3);
    wait_drain(2000);

    // three output blocks, slow dump stage stalls each squeeze
    clr_delay = 30;
    push_block(1'b1, 3, 0);
    send_block(1'b1, 3);
    wait_drain(2000);
    clr_delay = 10;

    // output_blocks = 0 acts like 1
    push_block(1'b1, 0, 0);
    send_block(1'b1, 0);
    wait_drain(500);

    // reset in the middle of the permutation
    ev_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 0));
    abs_gap_q.push_back(0);
    push_rounds(10);
    send_block(1'b1, 1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.round_enable && bus.round_index == 5'd10) found = 1'b1;
    end
    check("reached_round10", int'(found), 1);
    #1 rst = 1'b0;
    #1 check_all_zero("midreset");
    check("aborted_events_left", ev_q.size(), 0);
    ev_q.delete();
    ev_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_drain(20);

    push_block(1'b1, 1, 0);
    send_block(1'b1, 1);
    wait_drain(500);

    check("final_queue_empty", ev_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
